// File: rtl/r16_tf_rom_reader.sv
// r16_tf_rom_reader: radix-16 twiddle ROM read sequencer; define R16_TF_RD_CNT_EN to add the rd_cnt read counter
module r16_tf_rom_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int STAGE_NUM  = 2,
  parameter int ROM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [1:0]            stage_idx,
  output logic                  data_vld,
  output logic                  busy,
`ifdef R16_TF_RD_CNT_EN
  output logic                  done,
  output logic [15:0]           rd_cnt
`else
  output logic                  done
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] g_q, g_d, addr_q;
  logic [1:0] s_q, s_d, stg_q;
  logic [2:0] dr_q;
  logic [ROM_LAT-1:0] vld_q;
  logic accept, last_rd;
  assign accept  = state_q == IDLE && start;
  assign last_rd = rom_en && &g_q && s_q == 2'(STAGE_NUM - 1);
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start ? RUN : IDLE) :
              state_q == RUN   ? (last_rd ? DRAIN : RUN) :
              state_q == DRAIN ? (dr_q == 3'(ROM_LAT - 1) ? DONE : DRAIN) : IDLE;
  end
  always_comb begin
    rom_en    = state_q == RUN && !hold;
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    rom_addr  = rom_en ? g_q << {s_q, 2'b00} : addr_q;
    stage_idx = rom_en ? s_q : stg_q;
    data_vld  = vld_q[ROM_LAT-1];
  end
  always_comb begin
    g_d = accept ? '0 : rom_en ? g_q + 1'b1 : g_q;
    s_d = accept ? 2'd0 : (rom_en && &g_q) ? s_q + 2'd1 : s_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q    <= '0;
      s_q    <= '0;
      addr_q <= '0;
      stg_q  <= '0;
      dr_q   <= '0;
      vld_q  <= '0;
    end else begin
      g_q    <= g_d;
      s_q    <= s_d;
      addr_q <= rom_addr;
      stg_q  <= stage_idx;
      dr_q   <= state_q == DRAIN ? dr_q + 3'd1 : 3'd0;
      vld_q  <= ROM_LAT'({vld_q, rom_en});
    end
  end
`ifdef R16_TF_RD_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  assign rd_cnt_d = accept ? 16'd0 : (rom_en && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) rd_cnt_q <= '0;
    else rd_cnt_q <= rd_cnt_d;
  end
  assign rd_cnt = rd_cnt_q;
`endif
endmodule

// File: tb/tb_r16_tf_rom_reader.sv
// tb_r16_tf_rom_reader: scoreboard bench for the twiddle ROM read sequencer
module tb_r16_tf_rom_reader;
  logic clk = 0, rst = 1, start = 0, hold = 0;
  logic rom_en, data_vld, busy, done;
  logic [7:0] rom_addr;
  logic [1:0] stage_idx;
  logic s_start = 0, s_hold = 0;
  logic s_rom_en, s_vld, s_busy, s_done;
  logic [3:0] s_addr;
  logic [1:0] s_stage;
`ifdef R16_TF_RD_CNT_EN
  logic [15:0] rd_cnt, s_rd_cnt;
`endif
  int checks = 0, failures = 0, cyc = 0;
  int ts, nrd = 0, ndone = 0, first_rd, last_rd, last_vld, done_cyc;
  int exp_q[$], vq[$];
  r16_tf_rom_reader dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .rom_en(rom_en), .rom_addr(rom_addr), .stage_idx(stage_idx),
    .data_vld(data_vld), .busy(busy),
`ifdef R16_TF_RD_CNT_EN
    .rd_cnt(rd_cnt),
`endif
    .done(done)
  );
  r16_tf_rom_reader #(.ADDR_WIDTH(4), .STAGE_NUM(1), .ROM_LAT(1)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .hold(s_hold),
    .rom_en(s_rom_en), .rom_addr(s_addr), .stage_idx(s_stage),
    .data_vld(s_vld), .busy(s_busy),
`ifdef R16_TF_RD_CNT_EN
    .rd_cnt(s_rd_cnt),
`endif
    .done(s_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rom_en) begin
      if (nrd == 0) first_rd = cyc;
      last_rd = cyc;
      nrd++;
      chk("rd_addr", {22'd0, stage_idx, rom_addr}, exp_q.size() != 0 ? exp_q.pop_front() : -1);
      vq.push_back(cyc + 2);
    end
    if (data_vld) begin
      last_vld = cyc;
      chk("vld_cycle", cyc, vq.size() != 0 ? vq.pop_front() : -1);
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  end
  task automatic go(input logic h);
    for (int s = 0; s < 2; s++)
      for (int g = 0; g < 256; g++) exp_q.push_back((s << 8) | ((g << (4 * s)) & 255));
    nrd = 0;
    ndone = 0;
    @(posedge clk); #1 start = 1; hold = h; ts = cyc;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic wait_done(input int lim);
    int n0 = ndone;
    for (int i = 0; i < lim && ndone == n0; i++) @(posedge clk);
    chk("done_timeout", ndone != n0, 1);
  endtask
  task automatic wait_rd(input int k);
    for (int i = 0; i < 2000 && nrd < k; i++) @(posedge clk);
    chk("rd_timeout", nrd >= k, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_stage", stage_idx, 0);
    chk("rst_vld", data_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef R16_TF_RD_CNT_EN
    chk("rst_rd_cnt", rd_cnt, 0);
`endif
    repeat (5) @(posedge clk);
    go(0);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_rom_en", rom_en, 1);
    chk("t1_addr0", rom_addr, 0);
    wait_done(700);
    chk("t1_first_rd", first_rd, ts + 1);
    chk("t1_last_rd", last_rd, ts + 512);
    chk("t1_last_vld", last_vld, ts + 514);
    chk("t1_done_cyc", done_cyc, ts + 515);
    chk("t1_nrd", nrd, 512);
    @(negedge clk);
    chk("t1_busy_low", busy, 0);
    chk("t1_done_low", done, 0);
    chk("t1_exp_left", exp_q.size(), 0);
    chk("t1_vld_left", vq.size(), 0);
    go(0);
    wait_rd(3);
    #1 hold = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_en", rom_en, 0);
      chk("t2_hold_addr", rom_addr, 8'h02);
      chk("t2_hold_stage", stage_idx, 0);
      chk("t2_hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    hold = 0;
    wait_done(700);
    chk("t2_done_cyc", done_cyc, ts + 520);
    chk("t2_nrd", nrd, 512);
    go(0);
    wait_rd(100);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(700);
    repeat (10) @(posedge clk);
    chk("t3_nrd", nrd, 512);
    chk("t3_ndone", ndone, 1);
    go(0);
    wait_rd(200);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    exp_q.delete();
    vq.delete();
    @(negedge clk);
    chk("t4_rom_en", rom_en, 0);
    chk("t4_addr", rom_addr, 0);
    chk("t4_stage", stage_idx, 0);
    chk("t4_vld", data_vld, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    repeat (20) @(posedge clk);
    chk("t4_no_done", ndone, 0);
    go(0);
    wait_done(700);
    chk("t4_restart_first", first_rd, ts + 1);
    chk("t4_restart_nrd", nrd, 512);
    go(1);
    @(negedge clk);
    chk("t5_busy_hold", busy, 1);
    chk("t5_en_hold", rom_en, 0);
    for (int i = 0; i < 3000 && ndone == 0; i++) begin
      @(posedge clk); #1 hold = ($urandom_range(0, 3) == 0);
    end
    hold = 0;
    chk("t5_ndone", ndone, 1);
    chk("t5_nrd", nrd, 512);
    chk("t5_vld_left", vq.size(), 0);
`ifdef R16_TF_RD_CNT_EN
    repeat (3) @(posedge clk);
    chk("t5_rd_cnt", rd_cnt, 512);
    go(0);
    @(negedge clk);
    chk("t5_rd_cnt_clr", rd_cnt, 0);
    wait_done(700);
    chk("t5_rd_cnt_end", rd_cnt, 512);
`endif
    @(posedge clk); #1 s_start = 1;
    @(posedge clk); #1 s_start = 0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      chk("t6_rom_en", s_rom_en, i <= 16);
      if (i <= 16) chk("t6_addr", s_addr, i - 1);
      chk("t6_vld", s_vld, i >= 2 && i <= 17);
      chk("t6_done", s_done, i == 18);
      chk("t6_busy", s_busy, i <= 18);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
